// File: rtl/gpio_cfg_regbank_if.sv
// CPU-side register port of the GPIO config bank.
// Master drives requests; slave returns registered read data.
interface gpio_cfg_regbank_if #(
  parameter int AW = 2,
  parameter int DW = 8
);
  logic          ren_i;
  logic          wen_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] di_i;
  logic [DW-1:0] wm_i;
  logic [DW-1:0] do_o;
  logic          rvld_o;
  logic          err_o;

  modport master (
    output ren_i, wen_i, addr_i, di_i, wm_i,
    input  do_o, rvld_o, err_o
  );

  modport slave (
    input  ren_i, wen_i, addr_i, di_i, wm_i,
    output do_o, rvld_o, err_o
  );
endinterface

// File: rtl/gpio_cfg_regbank.sv
// GPIO config/status register bank: RW and W1C status
// registers, one-cycle read latency, status interrupt.
module gpio_cfg_regbank #(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int AW   = 2,
  parameter logic [NREG*DW-1:0] RST_VAL = '0,
  parameter logic [NREG-1:0]    ST_MASK = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  gpio_cfg_regbank_if.slave    bus,
  input  logic [NREG*DW-1:0]   set_i,
  input  logic                 clr_i,
  output logic [NREG*DW-1:0]   reg_o,
  output logic                 irq_o
);

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] sel;
  logic            addr_ok;
  logic [DW-1:0]   rd_mux;
  logic            irq_d;
  logic [DW-1:0]   do_q;
  logic            rvld_q;
  logic            err_q;
  logic            irq_q;

  // Address decode; addresses past NREG match nothing.
  always_comb begin
    sel     = '0;
    addr_ok = 1'b0;
    rd_mux  = '0;
    for (int k = 0; k < NREG; k++) begin
      sel[k] = (bus.addr_i == AW'(k));
      if (sel[k]) begin
        rd_mux = regs_q[k];
      end
    end
    addr_ok = |sel;
  end

  // Next register state: clear beats write/set.
  always_comb begin
    irq_d = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      logic          wr_hit;
      logic          st_upd;
      logic          rw_upd;
      logic [DW-1:0] w1c;
      regs_d[k] = regs_q[k];
      wr_hit = bus.wen_i & sel[k];
      st_upd = ~clr_i & ST_MASK[k];
      rw_upd = ~clr_i & ~ST_MASK[k] & wr_hit;
      w1c    = wr_hit ? (bus.di_i & bus.wm_i) : '0;
      unique case (1'b1)
        clr_i: begin
          regs_d[k] = RST_VAL[k*DW +: DW];
        end
        st_upd: begin
          regs_d[k] = set_i[k*DW +: DW]
                    | (regs_q[k] & ~w1c);
        end
        rw_upd: begin
          regs_d[k] = (regs_q[k] & ~bus.wm_i)
                    | (bus.di_i & bus.wm_i);
        end
        default: begin
          regs_d[k] = regs_q[k];
        end
      endcase
      if (ST_MASK[k] && (|regs_d[k])) begin
        irq_d = 1'b1;
      end
    end
  end

  // Register storage.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NREG; k++) begin
      if (rst) begin
        regs_q[k] <= RST_VAL[k*DW +: DW];
      end else begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  // Read response: old value, held until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      do_q   <= '0;
      rvld_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rvld_q <= bus.ren_i;
      err_q  <= (bus.ren_i | bus.wen_i) & ~addr_ok;
      if (bus.ren_i) begin
        do_q <= rd_mux;
      end
    end
  end

  // Interrupt tracks the status bits being registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  // Flatten register array onto reg_o.
  always_comb begin
    reg_o = '0;
    for (int k = 0; k < NREG; k++) begin
      reg_o[k*DW +: DW] = regs_q[k];
    end
  end

  assign bus.do_o   = do_q;
  assign bus.rvld_o = rvld_q;
  assign bus.err_o  = err_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_gpio_cfg_regbank.sv
// Bench for gpio_cfg_regbank: two configurations driven
// together, checked against a reference model every cycle.
module tb_gpio_cfg_regbank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic        clr = 1'b0;
  logic [1:0]  addr = '0;
  logic [7:0]  di = '0;
  logic [7:0]  wm = '0;
  logic [31:0] set_a = '0;
  logic [23:0] set_b = '0;
  logic [31:0] reg_a;
  logic [23:0] reg_b;
  logic        irq_a;
  logic        irq_b;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  gpio_cfg_regbank_if #(.AW(2), .DW(8)) ifa ();
  gpio_cfg_regbank_if #(.AW(2), .DW(8)) ifb ();

  assign ifa.ren_i  = ren;
  assign ifa.wen_i  = wen;
  assign ifa.addr_i = addr;
  assign ifa.di_i   = di;
  assign ifa.wm_i   = wm;
  assign ifb.ren_i  = ren;
  assign ifb.wen_i  = wen;
  assign ifb.addr_i = addr;
  assign ifb.di_i   = di;
  assign ifb.wm_i   = wm;

  gpio_cfg_regbank #(
    .DW(8), .NREG(4), .AW(2),
    .RST_VAL(32'h0000_5A00),
    .ST_MASK(4'b1000)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave),
    .set_i(set_a), .clr_i(clr),
    .reg_o(reg_a), .irq_o(irq_a)
  );

  gpio_cfg_regbank #(
    .DW(8), .NREG(3), .AW(2),
    .RST_VAL(24'h00_0011),
    .ST_MASK(3'b100)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave),
    .set_i(set_b), .clr_i(clr),
    .reg_o(reg_b), .irq_o(irq_b)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h",
                  nm, act, exp);
  endtask

  // Reference model: instance 0 = 4 regs, 1 = 3 regs.
  function automatic logic [7:0] rv(int i, int k);
    if (i == 0) return (k == 1) ? 8'h5A : 8'h00;
    return (k == 0) ? 8'h11 : 8'h00;
  endfunction

  function automatic bit isst(int i, int k);
    return (i == 0) ? (k == 3) : (k == 2);
  endfunction

  logic [7:0] mr [2][4];
  logic [7:0] mdo [2];
  bit         mrv [2];
  bit         mer [2];
  bit         mirq [2];
  bit         started = 0;

  // Compare outputs with the model, then advance the model
  // with the inputs the next rising edge will sample.
  always @(negedge clk) begin
    if (started) begin
      chk("a_do", 32'(ifa.do_o), 32'(mdo[0]));
      chk("a_rvld", 32'(ifa.rvld_o), 32'(mrv[0]));
      chk("a_err", 32'(ifa.err_o), 32'(mer[0]));
      chk("a_irq", 32'(irq_a), 32'(mirq[0]));
      chk("a_reg", reg_a,
          {mr[0][3], mr[0][2], mr[0][1], mr[0][0]});
      chk("b_do", 32'(ifb.do_o), 32'(mdo[1]));
      chk("b_rvld", 32'(ifb.rvld_o), 32'(mrv[1]));
      chk("b_err", 32'(ifb.err_o), 32'(mer[1]));
      chk("b_irq", 32'(irq_b), 32'(mirq[1]));
      chk("b_reg", 32'(reg_b),
          {8'h00, mr[1][2], mr[1][1], mr[1][0]});
    end
    for (int i = 0; i < 2; i++) begin
      int nr;
      bit ok;
      nr = (i == 0) ? 4 : 3;
      ok = int'(addr) < nr;
      if (rst) begin
        for (int k = 0; k < 4; k++) mr[i][k] = rv(i, k);
        mdo[i]  = 8'h00;
        mrv[i]  = 0;
        mer[i]  = 0;
        mirq[i] = 0;
      end else begin
        mrv[i] = ren;
        mer[i] = (ren || wen) && !ok;
        if (ren) mdo[i] = ok ? mr[i][addr] : 8'h00;
        for (int k = 0; k < nr; k++) begin
          logic [7:0] sb;
          bit hit;
          sb  = (i == 0) ? set_a[k*8 +: 8] : set_b[k*8 +: 8];
          hit = wen && (int'(addr) == k);
          if (clr) mr[i][k] = rv(i, k);
          else if (isst(i, k))
            mr[i][k] = sb | (mr[i][k] & ~(hit ? (di & wm) : 8'h00));
          else if (hit)
            mr[i][k] = (mr[i][k] & ~wm) | (di & wm);
        end
        mirq[i] = 0;
        for (int k = 0; k < nr; k++)
          if (isst(i, k) && mr[i][k] != 8'h00) mirq[i] = 1;
      end
    end
    if (rst) started = 1;
  end

  task automatic cyc(input logic r, input logic w,
                     input logic [1:0] a,
                     input logic [7:0] d,
                     input logic [7:0] m);
    ren = r; wen = w; addr = a; di = d; wm = m;
    @(posedge clk);
    #1;
    ren = 0; wen = 0; clr = 0;
    set_a = '0; set_b = '0;
  endtask

  initial begin
    // Read issued during reset gets no response.
    @(posedge clk); #1;
    cyc(1, 0, 2'd1, 8'h00, 8'h00);
    rst = 0;
    chk("rst_no_rvld", 32'(ifa.rvld_o), 32'd0);
    chk("rst_do", 32'(ifa.do_o), 32'd0);
    chk("rst_irq", 32'(irq_a), 32'd0);
    chk("rst_reg", reg_a, 32'h0000_5A00);
    @(posedge clk); #1;
    chk("rst_no_rvld2", 32'(ifa.rvld_o), 32'd0);

    // Back-to-back reads of every address.
    cyc(1, 0, 2'd0, 8'h00, 8'h00);
    chk("rd0", {31'd0, ifa.rvld_o, 8'h00} | 32'(ifa.do_o),
        32'h100);
    cyc(1, 0, 2'd1, 8'h00, 8'h00);
    chk("rd1", 32'(ifa.do_o), 32'h5A);
    cyc(1, 0, 2'd2, 8'h00, 8'h00);
    chk("rd2", 32'(ifa.do_o), 32'h00);
    cyc(1, 0, 2'd3, 8'h00, 8'h00);
    chk("rd3", 32'(ifa.do_o), 32'h00);
    chk("rd3_vld", 32'(ifa.rvld_o), 32'd1);

    // Masked RW write, then reads on consecutive cycles.
    cyc(0, 1, 2'd1, 8'hFF, 8'h0F);
    chk("rw_wr", reg_a, 32'h0000_5F00);
    chk("rw_novld", 32'(ifa.rvld_o), 32'd0);
    cyc(1, 0, 2'd1, 8'h00, 8'h00);
    chk("rd1_new", 32'(ifa.do_o), 32'h5F);
    cyc(1, 0, 2'd0, 8'h00, 8'h00);
    chk("rd0_b2b", 32'(ifa.do_o), 32'h00);
    chk("rd0_b2b_vld", 32'(ifa.rvld_o), 32'd1);

    // Status set raises irq; W1C clears it.
    set_a[26] = 1'b1;
    cyc(0, 0, 2'd0, 8'h00, 8'h00);
    chk("st_set", 32'(reg_a[31:24]), 32'h04);
    chk("st_irq1", 32'(irq_a), 32'd1);
    cyc(0, 1, 2'd3, 8'h04, 8'hFF);
    chk("st_w1c", 32'(reg_a[31:24]), 32'h00);
    chk("st_irq0", 32'(irq_a), 32'd0);

    // Set beats a simultaneous clear of the same bit.
    set_a[26] = 1'b1;
    cyc(0, 0, 2'd0, 8'h00, 8'h00);
    set_a[26] = 1'b1;
    cyc(0, 1, 2'd3, 8'h04, 8'hFF);
    chk("st_set_wins", 32'(reg_a[31:24]), 32'h04);

    // Read returns value before a same-cycle set.
    set_a[29] = 1'b1;
    cyc(1, 0, 2'd3, 8'h00, 8'h00);
    chk("rd_old", 32'(ifa.do_o), 32'h04);
    cyc(1, 0, 2'd3, 8'h00, 8'h00);
    chk("rd_new", 32'(ifa.do_o), 32'h24);

    // Invalid address on the 3-register bank.
    cyc(0, 1, 2'd3, 8'hFF, 8'hFF);
    chk("inv_wr_err", 32'(ifb.err_o), 32'd1);
    chk("inv_wr_vld", 32'(ifb.rvld_o), 32'd0);
    chk("inv_wr_reg", 32'(reg_b), 32'h00_0F11);
    cyc(1, 0, 2'd3, 8'h00, 8'h00);
    chk("inv_rd_do", 32'(ifb.do_o), 32'h00);
    chk("inv_rd_vld", 32'(ifb.rvld_o), 32'd1);
    chk("inv_rd_err", 32'(ifb.err_o), 32'd1);

    // Clear masks write and set in the same cycle.
    set_a[26] = 1'b1;
    cyc(0, 0, 2'd0, 8'h00, 8'h00);
    clr = 1; set_a = '1; set_b = '1;
    cyc(0, 1, 2'd1, 8'hFF, 8'hFF);
    chk("clr_a", reg_a, 32'h0000_5A00);
    chk("clr_irq", 32'(irq_a), 32'd0);
    chk("clr_b", 32'(reg_b), 32'h00_0011);

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      ren  = 1'($urandom_range(0, 1));
      wen  = 1'($urandom_range(0, 1));
      addr = 2'($urandom);
      di   = 8'($urandom);
      wm   = 8'($urandom);
      clr  = ($urandom_range(0, 39) == 0);
      rst  = ($urandom_range(0, 79) == 0);
      set_a = ($urandom_range(0, 2) == 0) ?
              (32'd1 << $urandom_range(0, 31)) : 32'd0;
      set_b = ($urandom_range(0, 2) == 0) ?
              24'(32'd1 << $urandom_range(0, 23)) : 24'd0;
      @(posedge clk); #1;
    end
    ren = 0; wen = 0; clr = 0; rst = 0;
    set_a = '0; set_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
